// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// instruction class enum, 4-bit class opcodes, 2-bit ALUOP codes, and the
// per-class control word produced by the decoder.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_ILLEGAL
  } cls_e;

  // Class codes live in the top four opcode bits.
  localparam logic [3:0] OP_ALU_R  = 4'b1111;
  localparam logic [3:0] OP_ALU_I0 = 4'b1000;
  localparam logic [3:0] OP_ALU_I1 = 4'b1001;
  localparam logic [3:0] OP_LOAD0  = 4'b1010;
  localparam logic [3:0] OP_LOAD1  = 4'b1100;
  localparam logic [3:0] OP_STORE0 = 4'b1011;
  localparam logic [3:0] OP_STORE1 = 4'b1101;
  localparam logic [3:0] OP_BR0    = 4'b0100;
  localparam logic [3:0] OP_BR1    = 4'b0101;
  localparam logic [3:0] OP_BR2    = 4'b0110;
  localparam logic [3:0] OP_JMP0   = 4'b0000;
  localparam logic [3:0] OP_JMP1   = 4'b0001;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_IMM = 2'b10;
  localparam logic [1:0] ALUOP_R   = 2'b11;

  typedef struct packed {
    logic       r15;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] aluop;
  } ctrl_t;

  // Width of the func pass-through; at least one bit even when OPW == 4.
  function automatic int func_w(input int opw);
    return (opw > 4) ? opw - 4 : 1;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Handshake, memory and control-strobe bundle of the multicycle control unit.
// master: instruction/memory source side (drives instr_valid, opcode,
//         mem_ack, trap_clr).
// slave:  the control unit (drives instr_ready, func, strobes, ALUOP, done,
//         illegal, timeout).
interface multicycle_control_if #(
  parameter int OPW     = 4,
  parameter int ALUOP_W = 2
);
  import multicycle_control_pkg::*;

  localparam int FW = func_w(OPW);

  logic               instr_valid;
  logic               instr_ready;
  logic [OPW-1:0]     opcode;
  logic [FW-1:0]      func;
  logic               mem_ack;
  logic               trap_clr;
  logic               R15;
  logic               ALUSrc;
  logic               MemToReg;
  logic               RegWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               Branch;
  logic               Jump;
  logic [ALUOP_W-1:0] ALUOP;
  logic               done;
  logic               illegal;
  logic               timeout;

  modport master (
    output instr_valid, opcode, mem_ack, trap_clr,
    input  instr_ready, func, R15, ALUSrc, MemToReg, RegWrite, MemRead,
           MemWrite, Branch, Jump, ALUOP, done, illegal, timeout
  );

  modport slave (
    input  instr_valid, opcode, mem_ack, trap_clr,
    output instr_ready, func, R15, ALUSrc, MemToReg, RegWrite, MemRead,
           MemWrite, Branch, Jump, ALUOP, done, illegal, timeout
  );

endinterface

// File: rtl/multicycle_control_opclass.sv
// Combinational class decoder.
// cls_code: 4-bit class field of the latched opcode.
// cls:      decoded instruction class (CL_ILLEGAL for unlisted codes).
// illegal:  1 when the code matches no class.
// ctrl:     R15 / ALUSrc / MemToReg / ALUOP word for the class, zero if illegal.
module opclass_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] cls_code,
  output cls_e       cls,
  output logic       illegal,
  output ctrl_t      ctrl
);

  always_comb begin
    cls  = CL_ILLEGAL;
    ctrl = '0;
    case (cls_code)
      OP_ALU_R: begin
        cls  = CL_ALU_R;
        ctrl = '{r15: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b1, aluop: ALUOP_R};
      end
      OP_ALU_I0, OP_ALU_I1: begin
        cls  = CL_ALU_I;
        ctrl = '{r15: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b1, aluop: ALUOP_IMM};
      end
      OP_LOAD0, OP_LOAD1: begin
        cls  = CL_LOAD;
        ctrl = '{r15: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, aluop: ALUOP_ADD};
      end
      OP_STORE0, OP_STORE1: begin
        cls  = CL_STORE;
        ctrl = '{r15: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, aluop: ALUOP_ADD};
      end
      OP_BR0, OP_BR1, OP_BR2: begin
        cls  = CL_BRANCH;
        ctrl = '{r15: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b0, aluop: ALUOP_BR};
      end
      OP_JMP0, OP_JMP1: begin
        cls  = CL_JUMP;
        ctrl = '{r15: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0, aluop: ALUOP_ADD};
      end
      default: ;
    endcase
    illegal = (cls == CL_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction control FSM.
// clk:   single clock, all state on its rising edge.
// reset: synchronous, active-high.
// bus:   slave side of multicycle_control_if (instruction handshake, opcode,
//        mem_ack, trap_clr in; control strobes, ALUOP, func, done, sticky
//        illegal/timeout flags out).
// Strobes are registered from the next state so they line up with the state
// they belong to; done is combinational because a STORE retires in the very
// cycle mem_ack arrives.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPW         = 4,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.slave   bus
);

  localparam int         FW       = func_w(OPW);
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e        state, state_n;
  logic [3:0]    cls_q;
  logic [FW-1:0] func_q;
  logic [7:0]    wait_cnt;
  ctrl_t         ctrl_q;
  logic          reg_write_q, mem_read_q, mem_write_q, branch_q, jump_q;
  logic          illegal_q, timeout_q;

  cls_e          dec_cls;
  logic          dec_illegal;
  ctrl_t         dec_ctrl;

  logic          accept;
  logic          tmo_hit;
  logic          done_c;

  opclass_decode u_dec (
    .cls_code (cls_q),
    .cls      (dec_cls),
    .illegal  (dec_illegal),
    .ctrl     (dec_ctrl)
  );

  assign accept  = (state == S_IDLE) && bus.instr_valid;
  // Last allowed no-ack MEM cycle; mem_ack in this same cycle still wins.
  assign tmo_hit = (state == S_MEM) && !bus.mem_ack && (wait_cnt == TMO_LAST);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (bus.instr_valid) state_n = S_DECODE;
      S_DECODE: state_n = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (dec_cls)
          CL_ALU_R, CL_ALU_I: state_n = S_WB;
          CL_LOAD, CL_STORE:  state_n = S_MEM;
          default:            state_n = S_IDLE;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack)  state_n = (dec_cls == CL_LOAD) ? S_WB : S_IDLE;
        else if (tmo_hit) state_n = S_TRAP;
      end
      S_WB:     state_n = S_IDLE;
      S_TRAP:   if (bus.trap_clr) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cls_q       <= '0;
      wait_cnt    <= '0;
      ctrl_q      <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) cls_q <= bus.opcode[OPW-1:OPW-4];

      // Class control word is captured out of DECODE and held until the
      // instruction leaves for IDLE or TRAP.
      if (state == S_DECODE && !dec_illegal) ctrl_q <= dec_ctrl;
      else if (state_n == S_IDLE || state_n == S_TRAP) ctrl_q <= '0;

      reg_write_q <= (state_n == S_WB);
      mem_read_q  <= (state_n == S_MEM) && (dec_cls == CL_LOAD);
      mem_write_q <= (state_n == S_MEM) && (dec_cls == CL_STORE);
      branch_q    <= (state_n == S_EXEC) && (dec_cls == CL_BRANCH);
      jump_q      <= (state_n == S_EXEC) && (dec_cls == CL_JUMP);

      if (state != S_MEM && state_n == S_MEM) wait_cnt <= '0;
      else if (state == S_MEM && !bus.mem_ack) wait_cnt <= wait_cnt + 8'd1;

      if (state == S_TRAP && bus.trap_clr) begin
        illegal_q <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        if (state == S_DECODE && dec_illegal) illegal_q <= 1'b1;
        if (tmo_hit) timeout_q <= 1'b1;
      end
    end
  end

  generate
    if (OPW > 4) begin : g_func
      always_ff @(posedge clk) begin
        if (reset)       func_q <= '0;
        else if (accept) func_q <= bus.opcode[OPW-5:0];
      end
    end else begin : g_nofunc
      assign func_q = '0;
    end
  endgenerate

  // Retire pulse; suppressed under reset so an abandoned STORE never reports.
  always_comb begin
    done_c = 1'b0;
    case (state)
      S_WB:   done_c = 1'b1;
      S_EXEC: done_c = (dec_cls == CL_BRANCH) || (dec_cls == CL_JUMP);
      S_MEM:  done_c = (dec_cls == CL_STORE) && bus.mem_ack;
      default: ;
    endcase
    if (reset) done_c = 1'b0;
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.func        = func_q;
  assign bus.R15         = ctrl_q.r15;
  assign bus.ALUSrc      = ctrl_q.alu_src;
  assign bus.MemToReg    = ctrl_q.mem_to_reg;
  assign bus.ALUOP       = ALUOP_W'(ctrl_q.aluop);
  assign bus.RegWrite    = reg_write_q;
  assign bus.MemRead     = mem_read_q;
  assign bus.MemWrite    = mem_write_q;
  assign bus.Branch      = branch_q;
  assign bus.Jump        = jump_q;
  assign bus.done        = done_c;
  assign bus.illegal     = illegal_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (default parameters).
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  multicycle_control_if #(.OPW(4), .ALUOP_W(2)) bus ();

  multicycle_control #(.OPW(4), .ALUOP_W(2), .MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    int ack_wait;   // MEM cycle index (0-based) carrying mem_ack, -1 = never
    int noise;      // mem_ack level driven outside MEM cycles
    int lat;        // expected done cycle, 0 = no done
    int aluop, r15, alusrc, m2r;
    int mr, mw, rw, br, jp;
    int ill, tmo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.ALUOP, bus.R15, bus.ALUSrc, bus.MemToReg, bus.RegWrite,
                 bus.MemRead, bus.MemWrite, bus.Branch, bus.Jump, bus.done,
                 bus.illegal, bus.timeout, bus.func});
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int  done_cyc = 0, done_n = 0, mr = 0, mw = 0, rw = 0, br = 0, jp = 0;
    int  mem_k = 0, aluop_s = 0, r15_s = 0, alusrc_s = 0, m2r_s = 0;
    bit  fin = 0;
    string tag;
    tag = $sformatf("v%0d_op%b", idx, v.op);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.instr_valid = 1'b1;
    bus.opcode = v.op;
    #1 chk({tag, "_ready"}, int'(bus.instr_ready), 1);
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      @(negedge clk);
      bus.instr_valid = (cyc < 3);           // must be ignored outside IDLE
      bus.opcode = 4'($urandom);
      if (bus.MemRead || bus.MemWrite) begin
        bus.mem_ack = (mem_k == v.ack_wait);
        mem_k++;
      end else begin
        bus.mem_ack = (v.noise != 0);
      end
      #1;
      if (bus.done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      mr += int'(bus.MemRead);
      mw += int'(bus.MemWrite);
      rw += int'(bus.RegWrite);
      br += int'(bus.Branch);
      jp += int'(bus.Jump);
      if (cyc == 2) begin
        aluop_s = int'(bus.ALUOP); r15_s = int'(bus.R15);
        alusrc_s = int'(bus.ALUSrc); m2r_s = int'(bus.MemToReg);
      end
      if (bus.instr_ready || bus.illegal || bus.timeout) fin = 1;
    end
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    chk({tag, "_finished"}, int'(fin), 1);
    chk({tag, "_done_cycle"}, done_cyc, v.lat);
    chk({tag, "_done_count"}, done_n, (v.lat != 0) ? 1 : 0);
    chk({tag, "_ctrl"}, (aluop_s << 3) | (r15_s << 2) | (alusrc_s << 1) | m2r_s,
        (v.aluop << 3) | (v.r15 << 2) | (v.alusrc << 1) | v.m2r);
    chk({tag, "_memread_cycles"}, mr, v.mr);
    chk({tag, "_memwrite_cycles"}, mw, v.mw);
    chk({tag, "_regwrite_cycles"}, rw, v.rw);
    chk({tag, "_branch_cycles"}, br, v.br);
    chk({tag, "_jump_cycles"}, jp, v.jp);
    chk({tag, "_illegal"}, int'(bus.illegal), v.ill);
    chk({tag, "_timeout"}, int'(bus.timeout), v.tmo);
    if (v.ill != 0 || v.tmo != 0) begin
      // TRAP holds everything down regardless of new offers.
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        bus.instr_valid = 1'b1;
        #1 chk({tag, "_trap_ready"}, int'(bus.instr_ready), 0);
        chk({tag, "_trap_strobes"}, outs() >> 3, 0);
      end
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.trap_clr = 1'b1;
      @(negedge clk);
      bus.trap_clr = 1'b0;
      #1 chk({tag, "_clr_ready"}, int'(bus.instr_ready), 1);
      chk({tag, "_clr_outputs"}, outs(), 0);
    end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.opcode = '0;
    bus.mem_ack = 1'b0;
    bus.trap_clr = 1'b0;

    //           op      ackw nz lat alu r15 src m2r mr mw rw br jp ill tmo
    tbl.push_back('{4'b1111, -1, 1,  3, 3, 1, 0, 1,  0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b1000, -1, 0,  3, 2, 0, 1, 1,  0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b1001, -1, 1,  3, 2, 0, 1, 1,  0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b1010,  2, 1,  6, 0, 0, 1, 0,  3, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b1100,  0, 0,  4, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b1011,  0, 1,  3, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b1101,  4, 0,  7, 0, 0, 1, 0,  0, 5, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0100, -1, 1,  2, 1, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{4'b0110, -1, 0,  2, 1, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{4'b0000, -1, 1,  2, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{4'b0111, -1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{4'b0010, -1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{4'b1110, -1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{4'b1101, -1, 0,  0, 0, 0, 1, 0,  0,15, 0, 0, 0, 0, 1});
    tbl.push_back('{4'b1010, 14, 0, 18, 0, 0, 1, 0, 15, 0, 1, 0, 0, 0, 0});

    // Reset state
    repeat (3) @(negedge clk);
    #1 chk("reset_ready", int'(bus.instr_ready), 1);
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    @(negedge clk);
    #1 chk("post_reset_ready", int'(bus.instr_ready), 1);
    chk("post_reset_outputs", outs(), 0);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Back-to-back: BRANCH 0101, then JUMP 0001 accepted in the next IDLE.
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.opcode = 4'b0101;      // c0
    @(negedge clk);
    bus.opcode = 4'b0001;                              // c1 (ignored)
    @(negedge clk);                                    // c2 EXEC
    #1 chk("b2b_branch", int'(bus.Branch), 1);
    chk("b2b_branch_done", int'(bus.done), 1);
    chk("b2b_branch_jump", int'(bus.Jump), 0);
    @(negedge clk);                                    // c3 IDLE, accepts
    #1 chk("b2b_ready", int'(bus.instr_ready), 1);
    @(negedge clk);                                    // c4 DECODE
    bus.instr_valid = 1'b0;
    #1 chk("b2b_busy", int'(bus.instr_ready), 0);
    @(negedge clk);                                    // c5 EXEC
    #1 chk("b2b_jump", int'(bus.Jump), 1);
    chk("b2b_jump_done", int'(bus.done), 1);
    chk("b2b_jump_branch", int'(bus.Branch), 0);
    @(negedge clk);
    #1 chk("b2b_idle", int'(bus.instr_ready), 1);

    // Reset inside MEM (LOAD 1100, then STORE 1101) with mem_ack high.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.opcode = (t == 0) ? 4'b1100 : 4'b1101;        // c0
      @(negedge clk);
      bus.instr_valid = 1'b0;                          // c1
      @(negedge clk);                                  // c2
      @(negedge clk);                                  // c3 MEM
      #1 chk("rst_mem_req", int'(bus.MemRead | bus.MemWrite), 1);
      @(negedge clk);                                  // c4 MEM
      reset = 1'b1;
      bus.mem_ack = 1'b1;
      #1 chk("rst_mem_no_done", int'(bus.done), 0);
      @(negedge clk);
      reset = 1'b0;
      bus.mem_ack = 1'b0;
      #1 chk("rst_mem_ready", int'(bus.instr_ready), 1);
      chk("rst_mem_outputs", outs(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPW, default 4: opcode width, >= 4; class decode uses opcode[OPW-1:OPW-4]; bits below pass through on func.
REQ-002 Parameter ALUOP_W, default 2: width of ALUOP; values zero-extended from the 2-bit table codes.
REQ-003 Parameter MEM_TIMEOUT, default 15: max cycles waiting for mem_ack, 1..255.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 instr_valid  in  1  opcode offered; instr_ready  out  1  block can accept.
REQ-007 opcode  in  OPW  instruction opcode; func  out  max(OPW-4,1)  latched low bits, zero when OPW=4.
REQ-008 mem_ack  in  1  memory completes the current request.
REQ-009 trap_clr  in  1  clears TRAP state.
REQ-010 R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump  out  1 each  registered control strobes.
REQ-011 ALUOP  out  ALUOP_W  ALU operation select.
REQ-012 done  out  1  one-cycle pulse, instruction retired; illegal, timeout  out  1  sticky error flags.

Function
REQ-013 FSM states SHALL be IDLE, DECODE, EXEC, MEM, WB, TRAP; instr_ready=1 only in IDLE.
REQ-014 IDLE with instr_valid=1 SHALL latch opcode and enter DECODE next cycle; instr_valid=0 stays IDLE.
REQ-015 DECODE SHALL register R15, ALUSrc, MemToReg, ALUOP per class: ALU-R 1111 {1,0,1,11}; ALU-I 1000/1001 {0,1,1,10}; LOAD 1010/1100 {0,1,0,00}; STORE 1011/1101 {0,1,0,00}; BRANCH 0100/0101/0110 {1,0,0,01}; JUMP 0000/0001 {0,0,0,00}.
REQ-016 Any other class code SHALL go DECODE->TRAP, set illegal, leave all strobes 0.
REQ-017 Sequences: ALU DECODE->EXEC->WB->IDLE; LOAD DECODE->EXEC->MEM->WB->IDLE; STORE DECODE->EXEC->MEM->IDLE; BRANCH and JUMP DECODE->EXEC->IDLE.
REQ-018 Branch SHALL be 1 only in EXEC for BRANCH; Jump only in EXEC for JUMP.
REQ-019 MemRead (LOAD) or MemWrite (STORE) SHALL be 1 for every MEM cycle and drop the cycle after mem_ack is sampled 1.
REQ-020 RegWrite SHALL be 1 only in WB.
REQ-021 R15, ALUSrc, MemToReg, ALUOP SHALL hold from the cycle after DECODE until return to IDLE, then go 0.
REQ-022 done SHALL pulse in the final state cycle (WB; MEM with ack for STORE; EXEC for BRANCH/JUMP).
REQ-023 Latency accept->done: ALU 3, BRANCH/JUMP 2, STORE 3+W, LOAD 4+W cycles, W = MEM wait cycles before ack.
REQ-024 An 8-bit wait counter SHALL clear on MEM entry, increment per MEM cycle without ack; at MEM_TIMEOUT cycles without ack go TRAP, set timeout, drop MemRead/MemWrite.
REQ-025 mem_ack outside MEM SHALL be ignored; mem_ack in the cycle the counter reaches MEM_TIMEOUT SHALL win (normal completion).
REQ-026 TRAP SHALL hold all strobes 0 and instr_ready 0 until trap_clr=1, then go IDLE and clear illegal and timeout.
REQ-027 instr_valid and opcode changes outside IDLE SHALL have no effect.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE, all outputs 0 except instr_ready=1 the following cycle, counter 0, flags clear.
REQ-029 Reset mid-instruction (any state, incl. MEM with request pending) SHALL abandon it with no done pulse; reset SHALL override trap_clr and mem_ack.

Structure
REQ-030 A shared package SHALL hold the state enum, 4-bit class opcode constants, and 2-bit ALUOP code constants.
REQ-031 Class decode SHALL be a combinational sub-module opclass_decode (class code in -> class enum, illegal bit, control word out).

Verification
REQ-032 Opcode 1111, valid 1 cycle -> ALUOP=11, R15=1, MemToReg=1; RegWrite in cycle 3 only; done at cycle 3.
REQ-033 Opcode 1010, mem_ack 2 cycles after MEM entry -> MemRead 3 cycles, RegWrite next cycle, done at cycle 6.
REQ-034 Opcode 1101, mem_ack never, MEM_TIMEOUT=15 -> MemWrite 15 cycles, TRAP, timeout=1; trap_clr -> IDLE, flags 0.
REQ-035 Opcode 0111 -> TRAP, illegal=1, no strobes, instr_ready 0 until trap_clr.
REQ-036 Opcode 0101 -> Branch=1 one cycle in EXEC, done same cycle; back-to-back 0001 accepted next cycle -> Jump=1.
REQ-037 reset during MEM of 1100 -> next cycle all strobes 0, instr_ready=1, no done.
